// File: rtl/hci_core_decoupler_pkg.sv
// Shared flit types and helpers for the per-channel HCI core decoupler.
package hci_core_decoupler_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned UW = 2;
    localparam int unsigned IW = 4;
    localparam int unsigned EW = 1;

    typedef struct packed {
        logic [AW-1:0] add;
        logic          wen;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [IW-1:0] id;
        logic [EW-1:0] ecc;
    } hci_core_req_flit_t;

    typedef struct packed {
        logic [DW-1:0] r_data;
        logic [UW-1:0] r_user;
        logic [IW-1:0] r_id;
        logic          r_opc;
        logic [EW-1:0] r_ecc;
    } hci_core_resp_flit_t;

    function automatic logic [3:0] pack_flags(
        input logic req_full,
        input logic req_empty,
        input logic resp_full,
        input logic resp_empty
    );
        return {req_full, req_empty, resp_full, resp_empty};
    endfunction

endpackage

// File: rtl/hci_core_decoupler_checker.sv
// Protocol and occupancy properties of the decoupler, kept apart from the datapath.
module hci_core_decoupler_checker #(
    parameter int unsigned REQ_DEPTH  = 2,
    parameter int unsigned RESP_DEPTH = 2,
    parameter int unsigned PLW        = 8
) (
    input logic                          clk_i,
    input logic                          rst_i,
    input logic                          clear_i,
    input logic                          ini_req,
    input logic                          ini_gnt,
    input logic [PLW-1:0]                ini_payload,
    input logic                          resp_push,
    input logic                          resp_full,
    input logic                          inflight,
    input logic [$clog2(REQ_DEPTH):0]    req_count,
    input logic [$clog2(RESP_DEPTH):0]   resp_count
);

    localparam int unsigned RQ_CW = $clog2(REQ_DEPTH) + 1;
    localparam int unsigned RS_CW = $clog2(RESP_DEPTH) + 1;

    a_resp_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        resp_push |-> !resp_full);

    a_req_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        req_count <= RQ_CW'(REQ_DEPTH));

    a_resp_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        resp_count <= RS_CW'(RESP_DEPTH));

    a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        ({1'b0, resp_count} + {{RS_CW{1'b0}}, inflight}) <= (RS_CW + 1)'(RESP_DEPTH));

    a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (ini_req && !ini_gnt && !clear_i) |=> (ini_req && $stable(ini_payload)));

endmodule

// File: rtl/hci_core_decoupler_fifo.sv
// Generic synchronous FIFO without fall-through; push while full is accepted only with a pop.
module hci_core_decoupler_fifo
    import hci_core_decoupler_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type T = logic
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    T               mem_r [DEPTH];
    logic [PW-1:0]  wptr_r;
    logic [PW-1:0]  rptr_r;
    logic [CW-1:0]  count_r;
    logic [CW-1:0]  count_nxt_s;
    logic           full_s;
    logic           empty_s;
    logic           push_ok_s;
    logic           pop_ok_s;

    assign full_s    = (count_r == CW'(DEPTH));
    assign empty_s   = (count_r == {CW{1'b0}});
    assign pop_ok_s  = pop & ~empty_s;
    assign push_ok_s = push & (~full_s | pop_ok_s);

    // Occupancy update from the accepted push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers and count; clear takes priority over any push or pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (clear_i) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_ok_s) wptr_r <= wptr_r + PW'(1'b1);
            if (pop_ok_s)  rptr_r <= rptr_r + PW'(1'b1);
            count_r <= count_nxt_s;
        end
    end

    // Storage array; contents are meaningless outside the valid window, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok_s && !clear_i) mem_r[wptr_r] <= push_data;
    end

    assign pop_data = mem_r[rptr_r];
    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_r;

endmodule

// File: rtl/hci_core_decoupler.sv
// Elastic request/response stage in front of the TCDM mux; issue is credit-gated so
// every response already owns a slot when it returns.
module hci_core_decoupler
    import hci_core_decoupler_pkg::*;
#(
    parameter int unsigned REQ_DEPTH  = 2,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    // streamer side
    input  logic          tcdm_target_req,
    output logic          tcdm_target_gnt,
    input  logic [AW-1:0] tcdm_target_add,
    input  logic          tcdm_target_wen,
    input  logic [BW-1:0] tcdm_target_be,
    input  logic [DW-1:0] tcdm_target_data,
    input  logic [UW-1:0] tcdm_target_user,
    input  logic [IW-1:0] tcdm_target_id,
    input  logic [EW-1:0] tcdm_target_ecc,
    output logic [DW-1:0] tcdm_target_r_data,
    output logic          tcdm_target_r_valid,
    input  logic          tcdm_target_r_ready,
    output logic [UW-1:0] tcdm_target_r_user,
    output logic [IW-1:0] tcdm_target_r_id,
    output logic          tcdm_target_r_opc,
    output logic [EW-1:0] tcdm_target_r_ecc,
    output logic          tcdm_target_egnt,
    output logic          tcdm_target_r_evalid,
    // mux side
    output logic          tcdm_initiator_req,
    input  logic          tcdm_initiator_gnt,
    output logic [AW-1:0] tcdm_initiator_add,
    output logic          tcdm_initiator_wen,
    output logic [BW-1:0] tcdm_initiator_be,
    output logic [DW-1:0] tcdm_initiator_data,
    output logic [UW-1:0] tcdm_initiator_user,
    output logic [IW-1:0] tcdm_initiator_id,
    output logic [EW-1:0] tcdm_initiator_ecc,
    input  logic [DW-1:0] tcdm_initiator_r_data,
    input  logic          tcdm_initiator_r_valid,
    output logic          tcdm_initiator_r_ready,
    input  logic [UW-1:0] tcdm_initiator_r_user,
    input  logic [IW-1:0] tcdm_initiator_r_id,
    input  logic          tcdm_initiator_r_opc,
    input  logic [EW-1:0] tcdm_initiator_r_ecc,
    output logic          tcdm_initiator_ereq,
    output logic          tcdm_initiator_r_eready,
    output logic [3:0]    flags_o
);

    localparam int unsigned RQ_CW = $clog2(REQ_DEPTH) + 1;
    localparam int unsigned RS_CW = $clog2(RESP_DEPTH) + 1;

    hci_core_req_flit_t   req_in_s;
    hci_core_req_flit_t   req_head_s;
    hci_core_resp_flit_t  resp_in_s;
    hci_core_resp_flit_t  resp_head_s;

    logic               req_push_s;
    logic               req_pop_s;
    logic               req_full_s;
    logic               req_empty_s;
    logic [RQ_CW-1:0]   req_count_s;
    logic               resp_push_s;
    logic               resp_pop_s;
    logic               resp_full_s;
    logic               resp_empty_s;
    logic [RS_CW-1:0]   resp_count_s;
    logic [RS_CW:0]     credits_used_s;
    logic               ini_req_s;
    logic               inflight_r;

    assign req_in_s = '{add:  tcdm_target_add,  wen: tcdm_target_wen, be: tcdm_target_be,
                        data: tcdm_target_data, user: tcdm_target_user,
                        id:   tcdm_target_id,   ecc: tcdm_target_ecc};

    assign resp_in_s = '{r_data: tcdm_initiator_r_data, r_user: tcdm_initiator_r_user,
                         r_id:   tcdm_initiator_r_id,   r_opc:  tcdm_initiator_r_opc,
                         r_ecc:  tcdm_initiator_r_ecc};

    assign req_push_s  = tcdm_target_req & ~req_full_s;
    assign req_pop_s   = ini_req_s & tcdm_initiator_gnt;
    // A response is only accepted when a grant is outstanding; stray r_valid is dropped.
    assign resp_push_s = tcdm_initiator_r_valid & inflight_r;
    assign resp_pop_s  = ~resp_empty_s & tcdm_target_r_ready;

    // Raise a request only when the in-flight and buffered responses leave a free slot.
    always_comb begin
        credits_used_s = {1'b0, resp_count_s} + {{RS_CW{1'b0}}, inflight_r};
        if (!req_empty_s && (credits_used_s < (RS_CW + 1)'(RESP_DEPTH))) begin
            ini_req_s = 1'b1;
        end else begin
            ini_req_s = 1'b0;
        end
    end

    // Outstanding-grant flag for the fixed one-cycle response latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_r <= 1'b0;
        end else if (clear_i) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= req_pop_s | (inflight_r & ~tcdm_initiator_r_valid);
        end
    end

    hci_core_decoupler_fifo #(
        .DEPTH (REQ_DEPTH),
        .T     (hci_core_req_flit_t)
    ) u_req_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .push      (req_push_s),
        .push_data (req_in_s),
        .pop       (req_pop_s),
        .pop_data  (req_head_s),
        .full      (req_full_s),
        .empty     (req_empty_s),
        .count     (req_count_s)
    );

    hci_core_decoupler_fifo #(
        .DEPTH (RESP_DEPTH),
        .T     (hci_core_resp_flit_t)
    ) u_resp_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .push      (resp_push_s),
        .push_data (resp_in_s),
        .pop       (resp_pop_s),
        .pop_data  (resp_head_s),
        .full      (resp_full_s),
        .empty     (resp_empty_s),
        .count     (resp_count_s)
    );

    assign tcdm_target_gnt      = ~req_full_s;
    assign tcdm_target_r_valid  = ~resp_empty_s;
    assign tcdm_target_r_data   = resp_head_s.r_data;
    assign tcdm_target_r_user   = resp_head_s.r_user;
    assign tcdm_target_r_id     = resp_head_s.r_id;
    assign tcdm_target_r_opc    = resp_head_s.r_opc;
    assign tcdm_target_r_ecc    = resp_head_s.r_ecc;
    assign tcdm_target_egnt     = 1'b1;
    assign tcdm_target_r_evalid = 1'b0;

    assign tcdm_initiator_req     = ini_req_s;
    assign tcdm_initiator_add     = req_head_s.add;
    assign tcdm_initiator_wen     = req_head_s.wen;
    assign tcdm_initiator_be      = req_head_s.be;
    assign tcdm_initiator_data    = req_head_s.data;
    assign tcdm_initiator_user    = req_head_s.user;
    assign tcdm_initiator_id      = req_head_s.id;
    assign tcdm_initiator_ecc     = req_head_s.ecc;
    assign tcdm_initiator_r_ready = 1'b1;
    assign tcdm_initiator_ereq    = 1'b0;
    assign tcdm_initiator_r_eready = 1'b1;

    assign flags_o = pack_flags(req_full_s, req_empty_s, resp_full_s, resp_empty_s);

    hci_core_decoupler_checker #(
        .REQ_DEPTH  (REQ_DEPTH),
        .RESP_DEPTH (RESP_DEPTH),
        .PLW        ($bits(hci_core_req_flit_t))
    ) u_checker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .ini_req     (ini_req_s),
        .ini_gnt     (tcdm_initiator_gnt),
        .ini_payload (req_head_s),
        .resp_push   (resp_push_s),
        .resp_full   (resp_full_s),
        .inflight    (inflight_r),
        .req_count   (req_count_s),
        .resp_count  (resp_count_s)
    );

endmodule

// File: tb/tb_hci_core_decoupler.sv
// Directed and random bench for hci_core_decoupler against a queue-level transaction model.
module tb_hci_core_decoupler;
    import hci_core_decoupler_pkg::*;

    localparam int REQ_D  = 2;
    localparam int RESP_D = 2;
    localparam int N_RAND = 6000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i, clear_i;
    logic tgt_req, tgt_gnt, tgt_wen, tgt_r_valid, tgt_r_ready, tgt_r_opc, tgt_egnt, tgt_r_evalid;
    logic [AW-1:0] tgt_add;
    logic [BW-1:0] tgt_be;
    logic [DW-1:0] tgt_data, tgt_r_data;
    logic [UW-1:0] tgt_user, tgt_r_user;
    logic [IW-1:0] tgt_id, tgt_r_id;
    logic [EW-1:0] tgt_ecc, tgt_r_ecc;
    logic ini_req, ini_gnt, ini_wen, ini_r_valid, ini_r_ready, ini_r_opc, ini_ereq, ini_r_eready;
    logic [AW-1:0] ini_add;
    logic [BW-1:0] ini_be;
    logic [DW-1:0] ini_data, ini_r_data;
    logic [UW-1:0] ini_user, ini_r_user;
    logic [IW-1:0] ini_id, ini_r_id;
    logic [EW-1:0] ini_ecc, ini_r_ecc;
    logic [3:0]    flags_o;

    hci_core_decoupler #(.REQ_DEPTH(REQ_D), .RESP_DEPTH(RESP_D)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
        .tcdm_target_req(tgt_req), .tcdm_target_gnt(tgt_gnt), .tcdm_target_add(tgt_add),
        .tcdm_target_wen(tgt_wen), .tcdm_target_be(tgt_be), .tcdm_target_data(tgt_data),
        .tcdm_target_user(tgt_user), .tcdm_target_id(tgt_id), .tcdm_target_ecc(tgt_ecc),
        .tcdm_target_r_data(tgt_r_data), .tcdm_target_r_valid(tgt_r_valid),
        .tcdm_target_r_ready(tgt_r_ready), .tcdm_target_r_user(tgt_r_user),
        .tcdm_target_r_id(tgt_r_id), .tcdm_target_r_opc(tgt_r_opc), .tcdm_target_r_ecc(tgt_r_ecc),
        .tcdm_target_egnt(tgt_egnt), .tcdm_target_r_evalid(tgt_r_evalid),
        .tcdm_initiator_req(ini_req), .tcdm_initiator_gnt(ini_gnt), .tcdm_initiator_add(ini_add),
        .tcdm_initiator_wen(ini_wen), .tcdm_initiator_be(ini_be), .tcdm_initiator_data(ini_data),
        .tcdm_initiator_user(ini_user), .tcdm_initiator_id(ini_id), .tcdm_initiator_ecc(ini_ecc),
        .tcdm_initiator_r_data(ini_r_data), .tcdm_initiator_r_valid(ini_r_valid),
        .tcdm_initiator_r_ready(ini_r_ready), .tcdm_initiator_r_user(ini_r_user),
        .tcdm_initiator_r_id(ini_r_id), .tcdm_initiator_r_opc(ini_r_opc),
        .tcdm_initiator_r_ecc(ini_r_ecc), .tcdm_initiator_ereq(ini_ereq),
        .tcdm_initiator_r_eready(ini_r_eready), .flags_o(flags_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model: what is buffered on each side and what is owed downstream.
    hci_core_req_flit_t  m_req_q[$];
    hci_core_resp_flit_t m_resp_q[$];
    bit                  m_inflight = 1'b0;
    hci_core_req_flit_t  m_inflight_txn;

    // Upstream streamer and downstream memory agents.
    hci_core_req_flit_t  up_q[$];
    bit                  up_hold = 1'b0;
    bit                  dn_pending = 1'b0;
    hci_core_req_flit_t  dn_txn;
    logic [AW-1:0]       issued_add[$];
    int                  up_pops = 0;
    int                  up_accepts = 0;
    bit k_gnt = 1'b0, k_rready = 1'b1, k_up_en = 1'b1, k_clear = 1'b0, k_stray = 1'b0;
    bit saw_req_full, saw_resp_full;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory behaviour: the response is a fixed function of the accepted request.
    function automatic hci_core_resp_flit_t mem_resp(input hci_core_req_flit_t q);
        hci_core_resp_flit_t r;
        r.r_data = {q.add[15:0], q.data[15:0]} ^ (q.wen ? 32'hFFFF_FFFF : 32'h0000_0000);
        r.r_user = q.user;
        r.r_id   = q.id;
        r.r_opc  = q.wen;
        r.r_ecc  = q.ecc ^ 1'b1;
        return r;
    endfunction

    function automatic bit m_ireq();
        return (m_req_q.size() > 0) && ((int'(m_inflight) + m_resp_q.size()) < RESP_D);
    endfunction

    function automatic bit m_idle();
        return (up_q.size() == 0) && (m_req_q.size() == 0) && !m_inflight &&
               (m_resp_q.size() == 0) && !dn_pending;
    endfunction

    task automatic check_all();
        chk("tgt_gnt", tgt_gnt, (m_req_q.size() < REQ_D));
        chk("ini_req", ini_req, m_ireq());
        chk("tgt_r_valid", tgt_r_valid, (m_resp_q.size() > 0));
        chk("flags", flags_o, {m_req_q.size() == REQ_D, m_req_q.size() == 0,
                               m_resp_q.size() == RESP_D, m_resp_q.size() == 0});
        chk("const_ties", {ini_r_ready, tgt_egnt, tgt_r_evalid, ini_ereq, ini_r_eready}, 5'b11001);
        if (m_ireq())
            chk("ini_payload", {ini_add, ini_wen, ini_be, ini_data, ini_user, ini_id, ini_ecc},
                m_req_q[0]);
        if (m_resp_q.size() > 0)
            chk("tgt_resp", {tgt_r_data, tgt_r_user, tgt_r_id, tgt_r_opc, tgt_r_ecc}, m_resp_q[0]);
    endtask

    // One clock: drive at the falling edge, advance model, compare at the next falling edge.
    task automatic tick();
        bit present, m_acc, m_iss, m_pop, m_push, dut_acc, dut_iss;
        hci_core_resp_flit_t dr;
        present = (up_q.size() > 0) && (up_hold || k_up_en);
        tgt_req = present;
        {tgt_add, tgt_wen, tgt_be, tgt_data, tgt_user, tgt_id, tgt_ecc} = present ? up_q[0] : '0;
        ini_gnt = k_gnt;
        tgt_r_ready = k_rready;
        clear_i = k_clear;
        dr = dn_pending ? mem_resp(dn_txn) : '1;
        ini_r_valid = dn_pending | k_stray;
        {ini_r_data, ini_r_user, ini_r_id, ini_r_opc, ini_r_ecc} = dr;

        m_acc  = present && (m_req_q.size() < REQ_D);
        m_iss  = m_ireq() && k_gnt;
        m_pop  = (m_resp_q.size() > 0) && k_rready;
        m_push = ini_r_valid && m_inflight;
        if (k_clear) begin
            m_req_q.delete();
            m_resp_q.delete();
            m_inflight = 1'b0;
        end else begin
            if (m_pop) void'(m_resp_q.pop_front());
            if (m_push) m_resp_q.push_back(mem_resp(m_inflight_txn));
            if (m_iss) m_inflight_txn = m_req_q.pop_front();
            m_inflight = m_iss;
            if (m_acc) m_req_q.push_back(up_q[0]);
        end

        dut_acc = present && tgt_gnt;
        dut_iss = ini_req && k_gnt;
        if (tgt_r_valid && k_rready) up_pops++;
        if (dut_acc) begin
            void'(up_q.pop_front());
            up_accepts++;
        end
        up_hold = present && !dut_acc;
        dn_pending = dut_iss;
        if (dut_iss) begin
            dn_txn = {ini_add, ini_wen, ini_be, ini_data, ini_user, ini_id, ini_ecc};
            issued_add.push_back(ini_add);
        end
        if (m_req_q.size() == REQ_D) saw_req_full = 1'b1;
        if (m_resp_q.size() == RESP_D) saw_resp_full = 1'b1;
        @(negedge clk);
        check_all();
    endtask

    task automatic drain(input string name);
        k_gnt = 1'b1; k_rready = 1'b1; k_up_en = 1'b1; k_clear = 1'b0; k_stray = 1'b0;
        for (int i = 0; i < 300 && !m_idle(); i++) tick();
        chk({name, "_drain"}, m_idle(), 1'b1);
    endtask

    function automatic hci_core_req_flit_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
        hci_core_req_flit_t q;
        q = '{add: a, wen: w, be: 4'hF, data: d, user: a[3:2], id: a[5:2], ecc: a[2]};
        return q;
    endfunction

    initial begin
        int base, sent, cyc;
        rst_i = 1'b1; clear_i = 1'b0; tgt_req = 1'b0; tgt_r_ready = 1'b1; ini_gnt = 1'b0;
        ini_r_valid = 1'b0;
        {tgt_add, tgt_wen, tgt_be, tgt_data, tgt_user, tgt_id, tgt_ecc} = '0;
        {ini_r_data, ini_r_user, ini_r_id, ini_r_opc, ini_r_ecc} = '0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        check_all();

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t1_flags", flags_o, 4'b0101);
            chk("t1_gnt", tgt_gnt, 1'b1);
        end

        // 2: single read with immediate downstream grant
        k_gnt = 1'b1;
        up_q.push_back(mk(32'h0000_0100, 1'b1, 32'h0));
        tick();
        chk("t2_req_c1", ini_req, 1'b1);
        chk("t2_add_c1", ini_add, 32'h0000_0100);
        tick();
        chk("t2_issued", issued_add.size(), 1);
        chk("t2_rvalid_c2", tgt_r_valid, 1'b0);
        tick();
        chk("t2_rvalid_c3", tgt_r_valid, 1'b1);
        chk("t2_rdata_c3", tgt_r_data, 32'hFEFF_FFFF);
        drain("t2");

        // 3: four back-to-back writes against a stalled mux
        issued_add.delete();
        k_gnt = 1'b0;
        up_accepts = 0;
        for (int i = 0; i < 4; i++) up_q.push_back(mk(32'(i * 4), 1'b0, 32'h1000 + 32'(i)));
        repeat (4) tick();
        chk("t3_accepts", up_accepts, 2);
        chk("t3_gnt_low", tgt_gnt, 1'b0);
        drain("t3");
        chk("t3_count", issued_add.size(), 4);
        for (int i = 0; i < 4 && i < issued_add.size(); i++)
            chk("t3_order", issued_add[i], 32'(i * 4));

        // 4: credit limit with the streamer refusing responses
        issued_add.delete();
        up_pops = 0;
        k_gnt = 1'b1; k_rready = 1'b0;
        for (int i = 0; i < 6; i++) up_q.push_back(mk(32'h200 + 32'(i * 4), 1'b1, 32'(i)));
        repeat (10) tick();
        chk("t4_grants", issued_add.size(), 2);
        chk("t4_req_low", ini_req, 1'b0);
        chk("t4_flags", flags_o, 4'b1010);
        k_rready = 1'b1;
        tick();
        k_rready = 1'b0;
        repeat (6) tick();
        chk("t4_grants_after_pulse", issued_add.size(), 3);
        drain("t4");
        chk("t4_responses", up_pops, 6);

        // 5: clear with queued requests and one grant outstanding
        k_gnt = 1'b0; k_rready = 1'b1;
        for (int i = 0; i < 3; i++) up_q.push_back(mk(32'h300 + 32'(i * 4), 1'b1, 32'h0));
        repeat (2) tick();
        k_gnt = 1'b1;
        tick();
        k_gnt = 1'b0; k_clear = 1'b1;
        tick();
        chk("t5_flags", flags_o, 4'b0101);
        chk("t5_req", ini_req, 1'b0);
        chk("t5_rvalid", tgt_r_valid, 1'b0);
        k_clear = 1'b0; k_stray = 1'b1;
        up_q.delete(); up_hold = 1'b0;
        tick();
        chk("t5_stray_rvalid", tgt_r_valid, 1'b0);
        chk("t5_stray_flags", flags_o, 4'b0101);
        k_stray = 1'b0;
        tick();
        chk("t5_late_rvalid", tgt_r_valid, 1'b0);

        // 6: random handshakes, in-order scoreboard through the model
        up_pops = 0; sent = 0; cyc = 0;
        saw_req_full = 1'b0; saw_resp_full = 1'b0;
        base = 32'h1_0000;
        while (up_pops < N_RAND && cyc < 60000) begin
            if (up_q.size() == 0 && sent < N_RAND) begin
                up_q.push_back('{add: 32'(base + sent * 4), wen: 1'($urandom_range(0, 1)),
                                 be: 4'($urandom), data: $urandom, user: 2'($urandom),
                                 id: 4'($urandom), ecc: 1'($urandom)});
                sent++;
            end
            k_gnt = 1'($urandom_range(0, 1));
            k_rready = 1'($urandom_range(0, 1));
            k_up_en = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        chk("t6_timeout", (up_pops >= N_RAND), 1'b1);
        chk("t6_req_full_seen", saw_req_full, 1'b1);
        chk("t6_resp_full_seen", saw_resp_full, 1'b1);
        drain("t6");
        chk("t6_responses", up_pops, N_RAND);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
